// File: rtl/read_data_control_pkg.sv
// Shared types for the PSL read-data path: command metadata, half-line output records and buffer-write beats.
package read_data_control_pkg;

  localparam int TAG_W     = 8;
  localparam int HALF_W    = 512;
  localparam int PAR_W     = 8;
  localparam int WORD_W    = HALF_W / PAR_W;
  localparam int TAG_DEPTH = 1 << TAG_W;

  localparam logic [7:0] INVALID_ID = 8'h00;
  localparam logic [7:0] WED_ID     = 8'hFE;

  typedef enum logic [3:0] {
    CMD_INVALID     = 4'd0,
    CMD_READ_CL_NA  = 4'd1,
    CMD_READ_CL_S   = 4'd2,
    CMD_READ_CL_LCK = 4'd3,
    CMD_WRITE_NA    = 4'd4
  } cmd_type_e;

  typedef struct packed {
    logic [7:0]       cu_id;
    cmd_type_e        cmd_type;
    logic [TAG_W-1:0] tag;
    logic [7:0]       cl_count;
  } CommandTagLine;

  typedef struct packed {
    logic              valid;
    CommandTagLine     cmd;
    logic [HALF_W-1:0] data;
  } ReadWriteDataLine;

  typedef struct packed {
    logic              bw_valid;
    logic [TAG_W-1:0]  bw_tag;
    logic [5:0]        bw_ad;
    logic [HALF_W-1:0] bw_data;
    logic [PAR_W-1:0]  bw_par;
  } BufferInterfaceInput;

  // One beat held in the lookup stage while the tag table read completes.
  typedef struct packed {
    logic              valid;
    logic              half;
    logic [HALF_W-1:0] data;
    logic [PAR_W-1:0]  par;
  } S1Beat;

  // Odd parity: returns 1 when the word and its parity bit carry an odd number of ones.
  function automatic logic parity_check_64(input logic [WORD_W-1:0] word, input logic par);
    return (^word) ^ par;
  endfunction

endpackage

// File: rtl/read_data_control_tag_table_ram.sv
// Command metadata store indexed by PSL tag: one write port, one registered read port.
module tag_table_ram
  import read_data_control_pkg::*;
(
  input  logic             clock,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_addr,
  input  CommandTagLine    wr_data,
  input  logic [TAG_W-1:0] rd_addr,
  output CommandTagLine    rd_data
);

  CommandTagLine mem [TAG_DEPTH];
  CommandTagLine rd_data_q;

  // Read returns the contents from before a same-cycle write.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/read_data_control.sv
// Routes PSL buffer-write beats to two half-cacheline streams tagged with the issuing command's metadata.
module read_data_control
  import read_data_control_pkg::*;
(
  input  logic              clock,
  input  logic              rstn,
  input  logic              enabled_in,
  input  logic              tag_alloc_valid,
  input  logic [TAG_W-1:0]  tag_alloc_tag,
  input  CommandTagLine     tag_alloc_cmd,
  input  logic              rsp_valid,
  input  logic [TAG_W-1:0]  rsp_tag,
  input  logic              bw_valid,
  input  logic [TAG_W-1:0]  bw_tag,
  input  logic [5:0]        bw_ad,
  input  logic [HALF_W-1:0] bw_data,
  input  logic [PAR_W-1:0]  bw_par,
  output ReadWriteDataLine  data_0_out,
  output ReadWriteDataLine  data_1_out,
  output logic              parity_err_out,
  output logic              tag_err_out
);

  BufferInterfaceInput    bw_in;
  logic                   unused_ad;
  logic                   enabled_q, enabled_d;
  logic [TAG_DEPTH-1:0]   tag_valid_q, tag_valid_d;
  S1Beat                  s1_q, s1_d;
  logic                   s1_hit_q, s1_hit_d;
  CommandTagLine          s1_cmd;
  logic [PAR_W-1:0]       word_ok;
  ReadWriteDataLine       data_0_q, data_0_d;
  ReadWriteDataLine       data_1_q, data_1_d;
  logic                   parity_err_q, parity_err_d;
  logic                   tag_err_q, tag_err_d;

  assign bw_in     = {bw_valid, bw_tag, bw_ad, bw_data, bw_par};
  assign unused_ad = ^bw_in.bw_ad[5:1];

  tag_table_ram u_tag_table (
    .clock   (clock),
    .wr_en   (tag_alloc_valid && enabled_q),
    .wr_addr (tag_alloc_tag),
    .wr_data (tag_alloc_cmd),
    .rd_addr (bw_in.bw_tag),
    .rd_data (s1_cmd)
  );

  for (genvar gi = 0; gi < PAR_W; gi++) begin : g_par
    assign word_ok[gi] = parity_check_64(s1_q.data[gi*WORD_W +: WORD_W], s1_q.par[gi]);
  end

  always_comb begin
    enabled_d = enabled_in;

    // Release first so that a same-cycle allocation of the same tag wins.
    tag_valid_d = tag_valid_q;
    if (rsp_valid) begin
      tag_valid_d[rsp_tag] = 1'b0;
    end
    if (tag_alloc_valid && enabled_q) begin
      tag_valid_d[tag_alloc_tag] = 1'b1;
    end

    s1_d.valid = bw_in.bw_valid && enabled_q;
    s1_d.half  = bw_in.bw_ad[0];
    s1_d.data  = bw_in.bw_data;
    s1_d.par   = bw_in.bw_par;
    s1_hit_d   = tag_valid_q[bw_in.bw_tag];

    data_0_d       = data_0_q;
    data_0_d.valid = 1'b0;
    data_1_d       = data_1_q;
    data_1_d.valid = 1'b0;
    if (s1_q.valid && s1_hit_q && enabled_q) begin
      if (s1_q.half) begin
        data_1_d = '{valid: 1'b1, cmd: s1_cmd, data: s1_q.data};
      end else begin
        data_0_d = '{valid: 1'b1, cmd: s1_cmd, data: s1_q.data};
      end
    end

    parity_err_d = parity_err_q | (s1_q.valid && !(&word_ok));
    tag_err_d    = tag_err_q | (s1_q.valid && !s1_hit_q);
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      enabled_q    <= 1'b0;
      tag_valid_q  <= '0;
      s1_q         <= '0;
      s1_hit_q     <= 1'b0;
      data_0_q     <= '0;
      data_1_q     <= '0;
      parity_err_q <= 1'b0;
      tag_err_q    <= 1'b0;
    end else begin
      enabled_q    <= enabled_d;
      tag_valid_q  <= tag_valid_d;
      s1_q         <= s1_d;
      s1_hit_q     <= s1_hit_d;
      data_0_q     <= data_0_d;
      data_1_q     <= data_1_d;
      parity_err_q <= parity_err_d;
      tag_err_q    <= tag_err_d;
    end
  end

  assign data_0_out     = data_0_q;
  assign data_1_out     = data_1_q;
  assign parity_err_out = parity_err_q;
  assign tag_err_out    = tag_err_q;

endmodule
